// File: rtl/dds_pkg.sv
// Shared encodings for the DDS frequency-sweep controller.
package dds_pkg;

    typedef enum logic [1:0] {
        SWEEP_SINGLE = 2'd0,
        SWEEP_SAW    = 2'd1,
        SWEEP_TRI    = 2'd2,
        SWEEP_RSVD   = 2'd3
    } sweep_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StDwell,
        StStep,
        StFin
    } sweep_state_e;

endpackage

// File: rtl/dds_sweep_step.sv
// Clamped next-point computation for the sweep; reverses direction when the
// current word already sits on the endpoint it is heading towards.
module dds_sweep_step #(
    parameter int unsigned FW = 8
) (
    input  logic [FW-1:0] kin,
    input  logic [FW-1:0] step,
    input  logic          dir,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    output logic [FW-1:0] next,
    output logic          at_end
);

    logic          eff_dir;
    logic [FW:0]   sum;
    logic [FW:0]   diff;

    assign at_end  = dir ? (kin == f_start) : (kin == f_stop);
    assign eff_dir = dir ^ at_end;
    assign sum     = {1'b0, kin} + {1'b0, step};
    assign diff    = {1'b0, kin} - {1'b0, step};

    always_comb begin
        next = kin;
        if (!eff_dir) begin
            next = (sum[FW] || (sum[FW-1:0] >= f_stop)) ? f_stop : sum[FW-1:0];
        end else begin
            // diff[FW] is the borrow out of the subtraction
            next = (diff[FW] || (diff[FW-1:0] <= f_start)) ? f_start : diff[FW-1:0];
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving the DDS frequency word and clock enable.
// Single, sawtooth and triangle sweeps with a programmable dwell per point.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned FW = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [CW-1:0] dwell,
    output logic [FW-1:0] kin_out,
    output logic          ce_out,
    output logic          busy,
    output logic          dir,
    output logic          done,
    output logic          cfg_err
);

    sweep_state_e  state_q;
    sweep_mode_e   mode_q;
    logic [FW-1:0] f_start_q;
    logic [FW-1:0] f_stop_q;
    logic [FW-1:0] f_step_q;
    logic [CW-1:0] dwell_q;
    logic [CW-1:0] cnt_q;
    logic [FW-1:0] kin_q;
    logic          dir_q;
    logic          busy_q;
    logic          ce_q;
    logic          done_q;
    logic          cfg_err_q;

    logic [FW-1:0] step_next;
    logic          at_end;
    logic          cfg_bad;

    assign cfg_bad = (f_step == '0) || (f_stop < f_start) || (mode == SWEEP_RSVD);

    dds_sweep_step #(
        .FW(FW)
    ) u_step (
        .kin    (kin_q),
        .step   (f_step_q),
        .dir    (dir_q),
        .f_start(f_start_q),
        .f_stop (f_stop_q),
        .next   (step_next),
        .at_end (at_end)
    );

    // The step is evaluated on the last dwell cycle, so StStep is never
    // resident and the new word follows the old one without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= SWEEP_SINGLE;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            kin_q     <= '0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            ce_q      <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            cfg_err_q <= 1'b0;
                            mode_q    <= sweep_mode_e'(mode);
                            f_start_q <= f_start;
                            f_stop_q  <= f_stop;
                            f_step_q  <= f_step;
                            dwell_q   <= dwell;
                            cnt_q     <= dwell;
                            kin_q     <= f_start;
                            dir_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            ce_q      <= 1'b1;
                            state_q   <= StDwell;
                        end
                    end
                end
                StDwell: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (at_end && (mode_q == SWEEP_SINGLE)) begin
                        busy_q  <= 1'b0;
                        ce_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        cnt_q <= dwell_q;
                        kin_q <= (at_end && (mode_q == SWEEP_SAW)) ? f_start_q : step_next;
                        if (at_end && (mode_q == SWEEP_TRI)) begin
                            dir_q <= ~dir_q;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ce_q    <= 1'b0;
                end
            endcase
        end
    end

    assign kin_out = kin_q;
    assign ce_out  = ce_q;
    assign busy    = busy_q;
    assign dir     = dir_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule
